result_demux: RTL and testbench
===============================

Name: result_demux

Overview:
- Registered 1-to-5 demultiplexer/router for 32-bit words; the inverse direction of the 5-input result mux.
- Accepts one word plus a 4-bit destination select per handshake and delivers it to one of five output lanes.
- Each lane has a one-entry holding register with valid/ready.
- Words with out-of-range selects are dropped, flagged and counted.
- Sits between the ALU result path and downstream consumers (register write, flags, memory address, etc.).

Parameters:
- WIDTH, 32, data width of input and every lane.
- LANES, 5, number of output lanes; must be <= 2**SELW.
- SELW, 4, width of the destination select.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  block accepts the word this cycle (combinational).
- in_sel  input  SELW  destination lane index.
- in_data  input  WIDTH  word to route.
- out_valid  output  LANES  bit k set means lane k holds a word.
- out_ready  input  LANES  bit k set means the lane k consumer takes the word.
- out_data  output  LANES*WIDTH  lane k data at bits [k*WIDTH +: WIDTH], registered.
- bad_sel  output  1  one-cycle pulse, registered: an out-of-range word was dropped.
- drop_count  output  CNTW  saturating count of dropped words.

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0, out_data = 0, bad_sel = 0, drop_count = 0.
  - Reset mid-transfer discards all held words; nothing is replayed.
- Accept: a word is accepted on a rising edge with in_valid & in_ready. No acceptance occurs while in_valid = 0.
- in_ready:
  - 1 if in_sel >= LANES (drop path never stalls).
  - Otherwise !out_valid[in_sel] | out_ready[in_sel].
  - Depends on in_sel and out_ready only; no dependence on in_data.
- Valid select:
  - Word is registered into lane in_sel; out_valid[in_sel] rises the next cycle.
  - Latency is exactly 1 cycle from accept to visible.
- Lane pop: out_valid[k] & out_ready[k] at an edge clears out_valid[k], unless the same lane is pushed in the same cycle.
- Simultaneous push and pop on the same lane:
  - out_data[k] takes the new word; out_valid[k] stays 1.
  - Full-throughput streaming is 1 word/cycle per lane.
- Lane independence:
  - A stalled lane blocks in_ready only for words targeting that lane.
  - Other lanes continue to pop freely.
- out_data[k] holds its value while out_valid[k] = 1 and no pop occurs. It is not cleared on pop (stale data with valid low).
- Invalid select (in_sel >= LANES, i.e. 5..15 at defaults):
  - Word is discarded; no lane changes.
  - bad_sel = 1 for exactly the following cycle.
  - drop_count increments, saturating at 2**CNTW-1 (255); it never wraps.
  - Back-to-back invalid words keep bad_sel high continuously and count each word.
- Only one input word is accepted per cycle.

Test Plan:
- Reset then idle:
  - Assert reset mid-cycle (asynchronously).
  - Required: out_valid = 5'b00000, drop_count = 0 and bad_sel = 0 immediately.
  - Required: in_ready = 1 for every in_sel.
- Sweep: send in_data = 2**i with in_sel = i for i = 0..4, with out_ready = 0.
  - Required: after the 5 accepts, out_valid = 5'b11111 and lane i data = 2**i (1, 2, 4, 8, 16).
  - Required: a sixth word with in_sel = 2 sees in_ready = 0.
- Backpressure and pass-through:
  - Hold lane 3 full with 0x8; keep in_valid = 1, in_sel = 3, in_data = 0xDEADBEEF; raise out_ready[3].
  - Required: the accept happens the same cycle; next cycle out_valid[3] = 1 and lane 3 data = 0xDEADBEEF.
- Invalid selects:
  - Send in_sel = 5, 7, 15 back-to-back.
  - Required: in_ready = 1 throughout, bad_sel high for 3 consecutive cycles, drop_count = 3, out_valid unchanged.
- Saturation: send 260 words with in_sel = 9.
  - Required: drop_count = 255 and no wrap to 0.
- Reset mid-operation:
  - With lanes 0 and 4 full, assert reset.
  - Required: out_valid = 0 and out_data = 0 asynchronously.
  - Required: after release, the first word with in_sel = 4 appears 1 cycle after accept.

Source files
------------

// File: rtl/result_demux.sv
// result_demux: registered 1-to-N router for ALU results.
// One-entry valid/ready holding register per lane; bad selects dropped and counted.
module result_demux #(
   parameter int WIDTH = 32,
   parameter int LANES = 5,
   parameter int SELW  = 4,
   parameter int CNTW  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SELW-1:0]        in_sel,
   input  logic [WIDTH-1:0]       in_data,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic                   bad_sel,
   output logic [CNTW-1:0]        drop_count
);

   localparam logic [SELW:0]   LANES_W = (SELW+1)'(LANES);
   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   logic             sel_ok;
   logic [LANES-1:0] hit;
   logic [LANES-1:0] lane_ready;
   logic [LANES-1:0] push;
   logic [LANES-1:0] pop;
   logic             drop;

   // Decode destination and derive per-lane push/pop and the input handshake.
   always_comb begin
      sel_ok = ({1'b0, in_sel} < LANES_W);
      hit = '0;
      lane_ready = '0;
      for (int k = 0; k < LANES; k++) begin
         hit[k] = (in_sel == SELW'(k));
         lane_ready[k] = !out_valid[k] || out_ready[k];
      end
      // Out-of-range words always drain so the drop path never stalls.
      in_ready = !sel_ok || |(hit & lane_ready);
      push = hit & lane_ready & {LANES{in_valid}};
      pop = out_valid & out_ready;
      drop = in_valid && !sel_ok;
   end

   // Lane holding registers; a push wins over a pop so streaming keeps valid high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= '0;
         out_data <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (push[k]) begin
               out_valid[k] <= 1'b1;
               out_data[k*WIDTH +: WIDTH] <= in_data;
            end else if (pop[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

   // Drop flag pulses the cycle after each dropped word; counter saturates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bad_sel <= 1'b0;
         drop_count <= '0;
      end else begin
         bad_sel <= drop;
         if (drop && drop_count != CNT_MAX) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_demux.sv
// tb_result_demux: directed vectors with hand-computed expectations
// for the result_demux router.
module tb_result_demux;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_sel;
   logic [31:0]  in_data;
   logic [4:0]   out_valid;
   logic [4:0]   out_ready;
   logic [159:0] out_data;
   logic         bad_sel;
   logic [7:0]   drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   result_demux dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sel(in_sel),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .bad_sel(bad_sel),
      .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] lane(input int k);
      return out_data[k*32 +: 32];
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      in_valid = 1'b0;
      in_sel = '0;
      in_data = '0;
      out_ready = '0;

      // asynchronous reset mid-cycle
      #3 reset = 1'b1;
      #1;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_cnt", 32'(drop_count), 32'h0);
      check("rst_bad", 32'(bad_sel), 32'h0);
      for (int s = 0; s < 16; s++) begin
         in_sel = 4'(s);
         #1;
         check($sformatf("rst_rdy%0d", s), 32'(in_ready), 32'h1);
      end
      @(posedge clk);
      #1 reset = 1'b0;

      // sweep all lanes with no consumer
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_sel = 4'(i);
         in_data = 32'(1) << i;
         tick();
      end
      in_valid = 1'b0;
      check("sweep_valid", 32'(out_valid), 32'h1f);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("sweep_d%0d", i), lane(i), 32'(1) << i);
      end
      in_valid = 1'b1;
      in_sel = 4'd2;
      #1;
      check("full_rdy2", 32'(in_ready), 32'h0);

      // backpressure then pass-through on lane 3
      in_sel = 4'd3;
      in_data = 32'hDEADBEEF;
      #1;
      check("bp_rdy3", 32'(in_ready), 32'h0);
      out_ready = 5'b01000;
      #1;
      check("pt_rdy3", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      out_ready = '0;
      check("pt_valid", 32'(out_valid), 32'h1f);
      check("pt_d3", lane(3), 32'hDEADBEEF);

      // pop lane 0 while lane 2 stays stalled
      out_ready = 5'b00001;
      in_valid = 1'b1;
      in_sel = 4'd2;
      in_data = 32'h1234;
      #1;
      check("ind_rdy2", 32'(in_ready), 32'h0);
      tick();
      in_valid = 1'b0;
      out_ready = '0;
      check("ind_valid", 32'(out_valid), 32'h1e);
      check("ind_d0_stale", lane(0), 32'h1);
      check("ind_d2", lane(2), 32'h4);

      // back-to-back invalid selects
      in_valid = 1'b1;
      in_data = 32'hBAD0BAD0;
      for (int i = 0; i < 3; i++) begin
         in_sel = (i == 0) ? 4'd5 : (i == 1) ? 4'd7 : 4'd15;
         #1;
         check($sformatf("inv_rdy%0d", i), 32'(in_ready), 32'h1);
         tick();
         check($sformatf("inv_bad%0d", i), 32'(bad_sel), 32'h1);
         check($sformatf("inv_cnt%0d", i), 32'(drop_count), 32'(i + 1));
      end
      in_valid = 1'b0;
      tick();
      check("inv_bad_end", 32'(bad_sel), 32'h0);
      check("inv_cnt_end", 32'(drop_count), 32'h3);
      check("inv_valid", 32'(out_valid), 32'h1e);

      // saturation: 260 more drops on top of 3
      in_valid = 1'b1;
      in_sel = 4'd9;
      for (int i = 1; i <= 260; i++) begin
         tick();
         if (i == 251) check("sat_254", 32'(drop_count), 32'd254);
         if (i == 252) check("sat_255", 32'(drop_count), 32'd255);
      end
      in_valid = 1'b0;
      check("sat_end", 32'(drop_count), 32'd255);
      check("sat_bad", 32'(bad_sel), 32'h1);

      // refill lane 0 so lanes 0 and 4 are full, then reset mid-cycle
      in_valid = 1'b1;
      in_sel = 4'd0;
      in_data = 32'h77;
      tick();
      in_valid = 1'b0;
      check("pre_valid", 32'(out_valid), 32'h1f);
      #2 reset = 1'b1;
      #1;
      check("mid_valid", 32'(out_valid), 32'h0);
      check("mid_cnt", 32'(drop_count), 32'h0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("mid_d%0d", i), lane(i), 32'h0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      in_valid = 1'b1;
      in_sel = 4'd4;
      in_data = 32'h44;
      #1;
      check("post_rdy4", 32'(in_ready), 32'h1);
      check("post_pre", 32'(out_valid), 32'h0);
      tick();
      in_valid = 1'b0;
      check("post_valid", 32'(out_valid), 32'h10);
      check("post_d4", lane(4), 32'h44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
